// File: rtl/apb_muldiv_engine.sv
// apb_muldiv_engine
//   APB2 arithmetic peripheral: signed/unsigned multiply (shift-add) and
//   divide (restoring). Both datapaths retire one operand bit per cycle.
//
// Ports
//   pclk     in   bus and core clock
//   presetn  in   asynchronous active-low reset
//   psel     in   slave select
//   penable  in   APB access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   [11:2] word address
//   pwdata   in   write data
//   prdata   out  combinational read data (0xFFFFFFFF when not reading)
//   irq      out  level interrupt = STATUS.done & CTRL.irq_en
//
// Registers (word offsets): 0 OPA, 1 OPB, 2 CTRL {irq_en,op,signed,start},
//   3 STATUS {start_err,div_by_zero,done,busy}, 4 RES_LO, 5 RES_HI.
module apb_muldiv_engine #(
    parameter int WIDTH       = 16,
    parameter bit IRQ_DEFAULT = 1'b0
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:2] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_FIX} state_e;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] opa_q, opb_q, res_lo_q, res_hi_q;
    logic             sgn_q, op_q, irq_en_q;
    logic             busy_q, done_q, dbz_q, serr_q;
    logic             done_d, dbz_d, serr_d;

    // Operation shadow and working registers
    logic [WIDTH-1:0] sh_a_q, sh_b_q;
    logic             sh_sgn_q, sh_div_q;
    logic             go_q;              // start accepted, LOAD begins next cycle
    logic [WIDTH-1:0] hi_q, lo_q, mb_q;  // hi: partial product / remainder, lo: multiplier / quotient
    logic             neg_q, rneg_q, bzero_q;
    logic [5:0]       cnt_q;

    // Bus decode
    logic wr, wr_opa, wr_opb, wr_ctrl, wr_stat;
    logic start_req, engaged, accept, start_err;

    assign wr        = psel & penable & pwrite;
    assign wr_opa    = wr & (paddr == 10'd0);
    assign wr_opb    = wr & (paddr == 10'd1);
    assign wr_ctrl   = wr & (paddr == 10'd2);
    assign wr_stat   = wr & (paddr == 10'd3);
    assign start_req = wr_ctrl & pwdata[0];
    assign engaged   = (state_q != S_IDLE) | go_q | busy_q;
    assign accept    = start_req & ~engaged;
    assign start_err = start_req & engaged;

    // FSM: state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go_q) state_d = S_LOAD;
            S_LOAD: state_d = S_CALC;
            S_CALC: if (cnt_q == LAST) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    logic enter_load, do_load, do_calc, do_fix;
    always_comb begin
        enter_load = (state_q == S_IDLE) & go_q;
        do_load    = (state_q == S_LOAD);
        do_calc    = (state_q == S_CALC);
        do_fix     = (state_q == S_FIX);
    end

    // Datapath step logic
    logic [WIDTH:0]     add_sum, rem_sh, rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] product, prod_fix;
    logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
    logic               sa, sb;

    always_comb begin
        sa       = sh_sgn_q & sh_a_q[WIDTH-1];
        sb       = sh_sgn_q & sh_b_q[WIDTH-1];
        // MIN maps to 2^(WIDTH-1), which still fits as an unsigned magnitude
        mag_a    = sa ? -sh_a_q : sh_a_q;
        mag_b    = sb ? -sh_b_q : sh_b_q;
        add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, mb_q};
        rem_ge   = (rem_sh >= {1'b0, mb_q});
        product  = {hi_q, lo_q};
        prod_fix = neg_q ? -product : product;
        quo_fix  = neg_q ? -lo_q : lo_q;
        rem_fix  = rneg_q ? -hi_q : hi_q;
    end

    // Status next state: a set in the same cycle as a W1C wins
    always_comb begin
        done_d = done_q;
        if (accept)                  done_d = 1'b0;
        if (wr_stat & pwdata[1])     done_d = 1'b0;
        if (do_fix)                  done_d = 1'b1;
        dbz_d = dbz_q;
        if (accept)                  dbz_d = 1'b0;
        if (do_fix)                  dbz_d = sh_div_q & bzero_q;
        serr_d = serr_q;
        if (wr_stat & pwdata[3])     serr_d = 1'b0;
        if (start_err)               serr_d = 1'b1;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            opa_q    <= '0;
            opb_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            sgn_q    <= 1'b0;
            op_q     <= 1'b0;
            irq_en_q <= IRQ_DEFAULT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            serr_q   <= 1'b0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_sgn_q <= 1'b0;
            sh_div_q <= 1'b0;
            go_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mb_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= done_d;
            dbz_q  <= dbz_d;
            serr_q <= serr_d;
            go_q   <= accept;
            if (wr_opa) opa_q <= pwdata[WIDTH-1:0];
            if (wr_opb) opb_q <= pwdata[WIDTH-1:0];
            if (wr_ctrl) begin
                sgn_q    <= pwdata[1];
                op_q     <= pwdata[2];
                irq_en_q <= pwdata[3];
            end
            // signed/op come from the start write itself so one CTRL write
            // both configures and launches the operation
            if (accept) begin
                sh_a_q   <= opa_q;
                sh_b_q   <= opb_q;
                sh_sgn_q <= pwdata[1];
                sh_div_q <= pwdata[2];
            end
            if (enter_load) busy_q <= 1'b1;
            if (do_load) begin
                lo_q    <= mag_a;
                mb_q    <= mag_b;
                hi_q    <= '0;
                neg_q   <= sa ^ sb;
                rneg_q  <= sa;
                bzero_q <= (sh_b_q == '0);
                cnt_q   <= '0;
            end
            if (do_calc) begin
                cnt_q <= cnt_q + 6'd1;
                if (sh_div_q) begin
                    hi_q <= rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], rem_ge};
                end else begin
                    hi_q <= add_sum[WIDTH:1];
                    lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
                end
            end
            if (do_fix) begin
                busy_q <= 1'b0;
                if (!sh_div_q) begin
                    res_lo_q <= prod_fix[WIDTH-1:0];
                    res_hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                end else if (bzero_q) begin
                    res_lo_q <= '1;
                    res_hi_q <= sh_a_q;
                end else begin
                    res_lo_q <= quo_fix;
                    res_hi_q <= rem_fix;
                end
            end
        end
    end

    assign irq = done_q & irq_en_q;

    always_comb begin
        prdata = '1;
        if (psel && !pwrite) begin
            prdata = '0;
            case (paddr)
                10'd0: prdata[WIDTH-1:0] = opa_q;
                10'd1: prdata[WIDTH-1:0] = opb_q;
                10'd2: prdata[3:1]       = {irq_en_q, op_q, sgn_q};
                10'd3: prdata[3:0]       = {serr_q, dbz_q, done_q, busy_q};
                10'd4: prdata[WIDTH-1:0] = res_lo_q;
                10'd5: prdata[WIDTH-1:0] = res_hi_q;
                default: prdata = '1;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pwdata, rem_sub[WIDTH]};

endmodule
